// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: branch-type encodings, control-bit layout,
// the EX/MEM buffer depth and the buffered entry format.
package cpu_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JAL  = 3'd7
  } br_type_e;

  // Bit positions of ctl: [2]=reg_write, [1]=mem_read, [0]=mem_write.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctl_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    ctl_t        ctl;
  } entry_t;

endpackage

// File: rtl/br_cond.sv
// Branch resolution: decides whether the presented branch/jump is taken from
// the ALU flags. `less` already carries signed or unsigned meaning.
module br_cond
  import cpu_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       equal,
  input  logic       less,
  output logic       taken
);

  always_comb begin
    // NOTE: default assignment first so every path drives taken; no latch.
    taken = 1'b0;
    case (br_type_e'(br_type))
      BR_BEQ:           taken = equal;
      BR_BNE:           taken = !equal;
      BR_BLT, BR_BLTU:  taken = less;
      BR_BGE, BR_BGEU:  taken = !less;
      BR_JAL:           taken = 1'b1;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: 2-entry in-order skid buffer toward MEM, plus registered
// redirect pulse and taken-branch counter for accepted taken branches/jumps.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      alu_result,
  input  logic             equal,
  input  logic             less,
  input  logic [2:0]       br_type,
  input  logic [31:0]      br_target,
  input  logic [31:0]      rs2_data,
  input  logic [4:0]       rd,
  input  logic [2:0]       ctl,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [31:0]      out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_ctl,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [1:0]       count;
  logic             rd_ptr;
  logic             wr_ptr;
  entry_t           buf_mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic             taken;
  logic             push;
  logic             pop;
  logic             taken_accept;
  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] taken_q;

  br_cond u_br_cond (
    .br_type (br_type),
    .equal   (equal),
    .less    (less),
    .taken   (taken)
  );

  // in_ready depends only on occupancy and reset, never on out_ready.
  assign in_ready     = (count < FULL_CNT) && !rst;
  assign out_valid    = (count != 2'd0) && !rst;
  assign push         = in_valid && in_ready && !flush;
  assign pop          = out_valid && out_ready && !flush;
  assign taken_accept = push && taken;

  assign in_entry = '{result: alu_result, rs2: rs2_data, rd: rd, ctl: ctl_t'(ctl)};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      taken_q       <= '0;
    end else if (flush) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      count      <= count + 2'(push) - 2'(pop);
      redirect_q <= taken_accept;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (taken_accept) begin
        redirect_pc_q <= br_target;
        taken_q       <= taken_q + 1'b1;
      end
    end
  end

  // NOTE: payload storage is not reset; occupancy alone qualifies its content.
  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= in_entry;
  end

  assign head       = buf_mem[rd_ptr];
  assign out_result = head.result;
  assign out_rs2    = head.rs2;
  assign out_rd     = head.rd;
  assign out_ctl    = head.ctl;

  // Registered outputs are forced to their idle values while reset is held.
  assign redirect    = redirect_q && !rst;
  assign redirect_pc = rst ? 32'd0 : redirect_pc_q;
  assign taken_count = rst ? '0 : taken_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic        equal;
  logic        less;
  logic [2:0]  br_type;
  logic [31:0] br_target;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic [2:0]  ctl;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_rs2;
  logic [4:0]  out_rd;
  logic [2:0]  out_ctl;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] taken_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  ctl;
  } mentry_t;

  mentry_t     mq[$];
  logic        m_redirect;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;

  ex_mem_stage #(.CNT_W(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .equal(equal), .less(less), .br_type(br_type),
    .br_target(br_target), .rs2_data(rs2_data), .rd(rd), .ctl(ctl),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_ctl(out_ctl), .redirect(redirect), .redirect_pc(redirect_pc),
    .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_taken(logic [2:0] bt, logic eq, logic ls);
    case (bt)
      3'd1:       return eq;
      3'd2:       return !eq;
      3'd3, 3'd5: return ls;
      3'd4, 3'd6: return !ls;
      3'd7:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Advance one clock and update the model from the inputs held across the edge.
  task automatic cycle();
    bit acc, pp, tk;
    mentry_t e;
    acc = in_valid && (mq.size() < 2) && !rst && !flush;
    pp  = (mq.size() != 0) && out_ready && !rst && !flush;
    tk  = acc && exp_taken(br_type, equal, less);
    e.res = alu_result; e.rs2 = rs2_data; e.rd = rd; e.ctl = ctl;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_redirect = 1'b0; m_pc = 32'd0; m_cnt = 16'd0;
    end else if (flush) begin
      mq.delete(); m_redirect = 1'b0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      m_redirect = tk;
      if (tk) begin
        m_pc  = br_target;
        m_cnt = m_cnt + 16'd1;
      end
    end
    #1;
  endtask

  task automatic drive_push(logic [31:0] res, logic [4:0] r, logic [2:0] c);
    in_valid = 1'b1; alu_result = res; rs2_data = ~res; rd = r; ctl = c;
    br_type = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; flush = 0; out_ready = 0; alu_result = 0;
    equal = 0; less = 0; br_type = 0; br_target = 0; rs2_data = 0; rd = 0; ctl = 0;
    cycle(); cycle();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    if (redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    if (taken_count !== 16'd0) begin errors++; $display("FAIL reset_taken_count got=%h exp=0", taken_count); end
  endtask

  task automatic test_single_push();
    rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    drive_push(32'h0000_0010, 5'd5, 3'b100);
    cycle();
    in_valid = 1'b0;
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL push_out_valid got=%b exp=1", out_valid); end
    if (out_result !== 32'h10) begin errors++; $display("FAIL push_out_result got=%h exp=10", out_result); end
    if (out_rd !== 5'd5) begin errors++; $display("FAIL push_out_rd got=%0d exp=5", out_rd); end
    if (out_ctl !== 3'b100) begin errors++; $display("FAIL push_out_ctl got=%b exp=100", out_ctl); end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_res [3];
    int idx;
    bit acc;
    exp_res[0] = 32'hAAAA_0001; exp_res[1] = 32'hBBBB_0002; exp_res[2] = 32'hCCCC_0003;
    out_ready = 1'b0;
    drive_push(exp_res[0], 5'd1, 3'b100); cycle();
    drive_push(exp_res[1], 5'd2, 3'b010); cycle();
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid got=%b exp=1", out_valid); end
    drive_push(exp_res[2], 5'd3, 3'b001); cycle(); cycle();
    checks += 2;
    if (out_result !== exp_res[0]) begin errors++; $display("FAIL held_head got=%h exp=%h", out_result, exp_res[0]); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL held_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    idx = 0;
    for (int n = 0; n < 10 && idx < 3; n++) begin
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_result !== exp_res[idx]) begin
          errors++; $display("FAIL order_%0d got=%h exp=%h", idx, out_result, exp_res[idx]);
        end
        idx++;
      end
      acc = in_valid && in_ready;
      cycle();
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (idx !== 3) begin errors++; $display("FAIL drain_count got=%0d exp=3", idx); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drained_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    drive_push(32'h0, 5'd0, 3'b000);
    br_type = 3'd3; less = 1'b1; equal = 1'b0; br_target = 32'h0000_0100;
    cycle();
    in_valid = 1'b0;
    checks += 3;
    if (redirect !== 1'b1) begin errors++; $display("FAIL blt_redirect got=%b exp=1", redirect); end
    if (redirect_pc !== 32'h100) begin errors++; $display("FAIL blt_pc got=%h exp=100", redirect_pc); end
    if (taken_count !== 16'd1) begin errors++; $display("FAIL blt_count got=%0d exp=1", taken_count); end
    cycle();
    checks++;
    if (redirect !== 1'b0) begin errors++; $display("FAIL pulse_width got=%b exp=0", redirect); end
    in_valid = 1'b1; br_type = 3'd4; less = 1'b1; br_target = 32'h200;
    cycle();
    in_valid = 1'b0;
    checks += 2;
    if (redirect !== 1'b0) begin errors++; $display("FAIL bge_redirect got=%b exp=0", redirect); end
    if (taken_count !== 16'd1) begin errors++; $display("FAIL bge_count got=%0d exp=1", taken_count); end
    cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_push(32'h11, 5'd1, 3'b100); cycle();
    drive_push(32'h22, 5'd2, 3'b100); cycle();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL preflush_valid got=%b exp=1", out_valid); end
    flush = 1'b1; in_valid = 1'b1; br_type = 3'd7; br_target = 32'h300;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got=%b exp=0", out_valid); end
    if (redirect !== 1'b0) begin errors++; $display("FAIL flush_full_redirect got=%b exp=0", redirect); end
    if (taken_count !== 16'd1) begin errors++; $display("FAIL flush_full_count got=%0d exp=1", taken_count); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready got=%b exp=1", in_ready); end
    // One entry buffered, JAL would be accepted and MEM would pop: flush wins.
    drive_push(32'h33, 5'd3, 3'b100); cycle();
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; br_type = 3'd7; br_target = 32'h400;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_valid got=%b exp=0", out_valid); end
    if (redirect !== 1'b0) begin errors++; $display("FAIL flush_one_redirect got=%b exp=0", redirect); end
    if (taken_count !== 16'd1) begin errors++; $display("FAIL flush_one_count got=%0d exp=1", taken_count); end
    // A redirect already registered survives a following flush.
    in_valid = 1'b1; br_type = 3'd7; br_target = 32'h500;
    cycle();
    in_valid = 1'b0; flush = 1'b1; #1;
    checks += 2;
    if (redirect !== 1'b1) begin errors++; $display("FAIL flush_keeps_redirect got=%b exp=1", redirect); end
    if (redirect_pc !== 32'h500) begin errors++; $display("FAIL flush_keeps_pc got=%h exp=500", redirect_pc); end
    cycle();
    flush = 1'b0;
    checks++;
    if (taken_count !== 16'd2) begin errors++; $display("FAIL flush_no_decrement got=%0d exp=2", taken_count); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive_push(32'h44, 5'd4, 3'b100); cycle();
    drive_push(32'h55, 5'd5, 3'b100); cycle();
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1; #1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_ready got=%b exp=0", in_ready); end
    if (redirect !== 1'b0) begin errors++; $display("FAIL rstfull_redirect got=%b exp=0", redirect); end
    if (redirect_pc !== 32'd0) begin errors++; $display("FAIL rstfull_pc got=%h exp=0", redirect_pc); end
    if (taken_count !== 16'd0) begin errors++; $display("FAIL rstfull_count got=%0d exp=0", taken_count); end
    cycle();
    rst = 1'b0; #1;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL after_rst_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL after_rst_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back_wrap();
    out_ready = 1'b1;
    drive_push(32'h0, 5'd1, 3'b100);
    br_type = 3'd7;
    for (int i = 0; i < 65535; i++) begin
      br_target = 32'(i) << 2;
      cycle();
      if (i < 8) begin
        checks += 2;
        if (redirect !== 1'b1) begin errors++; $display("FAIL b2b_redirect_%0d got=%b exp=1", i, redirect); end
        if (redirect_pc !== (32'(i) << 2)) begin
          errors++; $display("FAIL b2b_pc_%0d got=%h exp=%h", i, redirect_pc, 32'(i) << 2);
        end
      end
    end
    checks++;
    if (taken_count !== 16'hFFFF) begin errors++; $display("FAIL count_max got=%h exp=ffff", taken_count); end
    br_type = 3'd1; equal = 1'b1; br_target = 32'h600;
    cycle();
    in_valid = 1'b0; equal = 1'b0;
    checks += 2;
    if (taken_count !== 16'h0000) begin errors++; $display("FAIL count_wrap got=%h exp=0000", taken_count); end
    if (redirect_pc !== 32'h600) begin errors++; $display("FAIL wrap_pc got=%h exp=600", redirect_pc); end
    cycle();
  endtask

  task automatic test_random();
    bit exp_valid;
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 40) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      br_type    = 3'($urandom_range(0, 7));
      equal      = 1'($urandom);
      less       = 1'($urandom);
      br_target  = $urandom;
      alu_result = $urandom;
      rs2_data   = $urandom;
      rd         = 5'($urandom);
      ctl        = 3'($urandom);
      #1;
      exp_valid = (mq.size() != 0) && !rst;
      checks += 4;
      if (in_ready !== ((mq.size() < 2) && !rst)) begin
        errors++; $display("FAIL rnd_in_ready n=%0d got=%b exp=%b", n, in_ready, (mq.size() < 2) && !rst);
      end
      if (out_valid !== exp_valid) begin
        errors++; $display("FAIL rnd_out_valid n=%0d got=%b exp=%b", n, out_valid, exp_valid);
      end
      if (redirect !== (m_redirect && !rst)) begin
        errors++; $display("FAIL rnd_redirect n=%0d got=%b exp=%b", n, redirect, m_redirect && !rst);
      end
      if (taken_count !== (rst ? 16'd0 : m_cnt)) begin
        errors++; $display("FAIL rnd_count n=%0d got=%h exp=%h", n, taken_count, rst ? 16'd0 : m_cnt);
      end
      if (exp_valid) begin
        checks += 4;
        if (out_result !== mq[0].res) begin errors++; $display("FAIL rnd_result n=%0d got=%h exp=%h", n, out_result, mq[0].res); end
        if (out_rs2 !== mq[0].rs2) begin errors++; $display("FAIL rnd_rs2 n=%0d got=%h exp=%h", n, out_rs2, mq[0].rs2); end
        if (out_rd !== mq[0].rd) begin errors++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, out_rd, mq[0].rd); end
        if (out_ctl !== mq[0].ctl) begin errors++; $display("FAIL rnd_ctl n=%0d got=%b exp=%b", n, out_ctl, mq[0].ctl); end
      end
      if (m_redirect && !rst) begin
        checks++;
        if (redirect_pc !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, redirect_pc, m_pc); end
      end
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_backpressure();
    test_branch();
    test_flush();
    test_reset_full();
    rst = 1'b1; cycle(); rst = 1'b0;
    test_back_to_back_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
